// File: rtl/sparc_ctrl_pkg.sv
// Shared encodings for the SPARC-V8 subset multicycle control sequencer:
// state set, instruction field constants, datapath select codes and fault codes.
package sparc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_EXEC_ALU,
    S_EXEC_ADDR,
    S_LD_WAIT,
    S_LD_WB,
    S_ST_DATA,
    S_ST_WAIT,
    S_BRANCH,
    S_PC_UPD,
    S_FAULT
  } state_t;

  localparam logic [1:0] OP_FMT2 = 2'd0;
  localparam logic [1:0] OP_ALU  = 2'd2;
  localparam logic [1:0] OP_MEM  = 2'd3;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam logic [5:0] OP3_ADD = 6'h00;
  localparam logic [5:0] OP3_AND = 6'h01;
  localparam logic [5:0] OP3_OR  = 6'h02;
  localparam logic [5:0] OP3_XOR = 6'h03;
  localparam logic [5:0] OP3_SUB = 6'h04;

  localparam logic [5:0] OP3_LD   = 6'h00;
  localparam logic [5:0] OP3_LDUB = 6'h01;
  localparam logic [5:0] OP3_ST   = 6'h04;
  localparam logic [5:0] OP3_STB  = 6'h05;

  localparam logic [1:0] EXT_SIMM13 = 2'd0;
  localparam logic [1:0] EXT_DISP22 = 2'd1;
  localparam logic [1:0] EXT_IMM22  = 2'd2;

  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_EXT  = 2'd1;
  localparam logic [1:0] ALUB_FOUR = 2'd2;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_FETCH_TO = 2'd1;
  localparam logic [1:0] FAULT_DATA_TO  = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'd3;

  // op3[4] is the "set condition codes" variant of each ALU operation.
  function automatic logic is_alu_op3(input logic [5:0] op3);
    return (op3[5] == 1'b0) && (op3[3] == 1'b0) && (op3[2:0] <= 3'd4);
  endfunction

  function automatic logic is_mem_op3(input logic [5:0] op3);
    return (op3 == OP3_LD) || (op3 == OP3_LDUB) || (op3 == OP3_ST) || (op3 == OP3_STB);
  endfunction

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FWAIT) || (s == S_LD_WAIT) || (s == S_ST_WAIT);
  endfunction

endpackage

// File: rtl/sparc_control_fsm_icc_cond_eval.sv
// Bicc condition evaluator: the lower three cond bits pick a base test on
// {N,Z,V,C}; cond[3] inverts it, giving all 16 branch conditions.
module icc_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] icc,
  output logic       taken
);

  logic n, z, v, c;
  logic base;

  assign {n, z, v, c} = icc;

  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      3'd7: base = v;
      default: base = 1'b0;
    endcase
    taken = base ^ cond[3];
  end

endmodule

// File: rtl/sparc_control_fsm.sv
// Multicycle control sequencer: fetches through a RAM handshake, decodes the
// IR and strobes datapath enables; a missing mfc or bad opcode latches a fault.
module sparc_control_fsm
  import sparc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int MFC_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           ir_out,
  input  logic                  mfc,
  input  logic [3:0]            icc,
  output logic                  npc_enable,
  output logic                  pc_enable,
  output logic                  ir_enable,
  output logic                  mdr_enable,
  output logic                  mar_enable,
  output logic                  rf_write,
  output logic                  ram_enable,
  output logic                  psr_enable,
  output logic [1:0]            extender_select,
  output logic [1:0]            alub_mux_select,
  output logic                  mdr_mux_select,
  output logic [REG_ADDR_W-1:0] in_pc,
  output logic [REG_ADDR_W-1:0] in_pa,
  output logic [REG_ADDR_W-1:0] in_pb,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [ALU_OP_W-1:0]   ram_opcode,
  output logic                  mem_fault,
  output logic [1:0]            fault_code
);

  localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(MFC_TIMEOUT);

  state_t state, state_nxt;
  logic [1:0]       fault_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             timeout;
  logic             br_taken;

  logic [1:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] op2;
  logic [5:0] op3;
  logic [3:0] cond;
  logic       i_bit;
  logic       is_sethi, is_branch, alu_legal, mem_legal;
  logic [7:0] unused_ir_bits;

  assign op    = ir_out[31:30];
  assign rd    = ir_out[29:25];
  assign cond  = ir_out[28:25];
  assign op2   = ir_out[24:22];
  assign op3   = ir_out[24:19];
  assign rs1   = ir_out[18:14];
  assign i_bit = ir_out[13];
  assign rs2   = ir_out[4:0];
  assign unused_ir_bits = ir_out[12:5];

  assign is_sethi  = (op == OP_FMT2) && (op2 == OP2_SETHI);
  assign is_branch = (op == OP_FMT2) && (op2 == OP2_BICC);
  assign alu_legal = (op == OP_ALU) && is_alu_op3(op3);
  assign mem_legal = (op == OP_MEM) && is_mem_op3(op3);

  // The cycle that would be the MFC_TIMEOUT-th one without mfc trips the fault.
  assign cnt_inc = {1'b0, wait_cnt} + 1'b1;
  assign timeout = !mfc && (cnt_inc >= TIMEOUT_LIM);

  icc_cond_eval u_cond (
    .cond  (cond),
    .icc   (icc),
    .taken (br_taken)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_RST;
      wait_cnt   <= '0;
      fault_code <= FAULT_NONE;
    end else begin
      state      <= state_nxt;
      fault_code <= fault_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (is_wait_state(state) && !mfc)
        wait_cnt <= cnt_inc[CNT_W-1:0];
    end
  end

  always_comb begin
    state_nxt       = state;
    fault_nxt       = fault_code;
    npc_enable      = 1'b0;
    pc_enable       = 1'b0;
    ir_enable       = 1'b0;
    mdr_enable      = 1'b0;
    mar_enable      = 1'b0;
    rf_write        = 1'b0;
    ram_enable      = 1'b0;
    psr_enable      = 1'b0;
    extender_select = EXT_SIMM13;
    alub_mux_select = ALUB_REG;
    mdr_mux_select  = 1'b0;
    in_pc           = '0;
    in_pa           = '0;
    in_pb           = '0;
    alu_op          = '0;
    ram_opcode      = '0;
    mem_fault       = 1'b0;

    case (state)
      S_RST: state_nxt = S_FETCH;

      S_FETCH: begin
        mar_enable = 1'b1;
        state_nxt  = S_FWAIT;
      end

      S_FWAIT: begin
        ram_enable = 1'b1;
        ir_enable  = mfc;
        if (mfc) begin
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_FAULT;
          fault_nxt = FAULT_FETCH_TO;
        end
      end

      S_DECODE: begin
        if (alu_legal || is_sethi)
          state_nxt = S_EXEC_ALU;
        else if (mem_legal)
          state_nxt = S_EXEC_ADDR;
        else if (is_branch)
          state_nxt = S_BRANCH;
        else begin
          state_nxt = S_FAULT;
          fault_nxt = FAULT_ILLEGAL;
        end
      end

      // sethi is computed as r0 + (imm22<<10) through the adder.
      S_EXEC_ALU: begin
        rf_write = (rd != 5'd0);
        in_pc    = REG_ADDR_W'(rd);
        if (is_sethi) begin
          alub_mux_select = ALUB_EXT;
          extender_select = EXT_IMM22;
          alu_op          = ALU_OP_W'(OP3_ADD);
        end else begin
          in_pa           = REG_ADDR_W'(rs1);
          in_pb           = REG_ADDR_W'(rs2);
          psr_enable      = op3[4];
          alu_op          = ALU_OP_W'(op3);
          alub_mux_select = i_bit ? ALUB_EXT : ALUB_REG;
        end
        state_nxt = S_PC_UPD;
      end

      S_EXEC_ADDR: begin
        mar_enable      = 1'b1;
        in_pa           = REG_ADDR_W'(rs1);
        in_pb           = REG_ADDR_W'(rs2);
        alu_op          = ALU_OP_W'(OP3_ADD);
        alub_mux_select = i_bit ? ALUB_EXT : ALUB_REG;
        state_nxt       = op3[2] ? S_ST_DATA : S_LD_WAIT;
      end

      S_LD_WAIT: begin
        ram_enable = 1'b1;
        ram_opcode = ALU_OP_W'(op3);
        mdr_enable = mfc;
        if (mfc) begin
          state_nxt = S_LD_WB;
        end else if (timeout) begin
          state_nxt = S_FAULT;
          fault_nxt = FAULT_DATA_TO;
        end
      end

      S_LD_WB: begin
        rf_write  = (rd != 5'd0);
        in_pc     = REG_ADDR_W'(rd);
        state_nxt = S_PC_UPD;
      end

      S_ST_DATA: begin
        mdr_mux_select = 1'b1;
        mdr_enable     = 1'b1;
        in_pb          = REG_ADDR_W'(rd);
        state_nxt      = S_ST_WAIT;
      end

      S_ST_WAIT: begin
        ram_enable = 1'b1;
        ram_opcode = ALU_OP_W'(op3);
        if (mfc) begin
          state_nxt = S_PC_UPD;
        end else if (timeout) begin
          state_nxt = S_FAULT;
          fault_nxt = FAULT_DATA_TO;
        end
      end

      S_BRANCH: begin
        npc_enable = 1'b1;
        alu_op     = ALU_OP_W'(OP3_ADD);
        if (br_taken) begin
          alub_mux_select = ALUB_EXT;
          extender_select = EXT_DISP22;
        end else begin
          alub_mux_select = ALUB_FOUR;
        end
        state_nxt = S_PC_UPD;
      end

      // A branch already loaded nPC, so only PC advances here.
      S_PC_UPD: begin
        pc_enable = 1'b1;
        if (!is_branch) begin
          npc_enable      = 1'b1;
          alub_mux_select = ALUB_FOUR;
          alu_op          = ALU_OP_W'(OP3_ADD);
        end
        state_nxt = S_FETCH;
      end

      S_FAULT: mem_fault = 1'b1;

      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_sparc_control_fsm.sv
// Bench for sparc_control_fsm: a per-instruction reference model expands each
// instruction and its mfc delays into expected per-cycle strobes and selects.
module tb_sparc_control_fsm;

  localparam int T = 15;
  localparam int E_NPC = 7, E_PC = 6, E_IR = 5, E_MDR = 4;
  localparam int E_MAR = 3, E_RF = 2, E_RAM = 1, E_PSR = 0;

  logic        clk = 1'b0;
  logic        reset_n, mfc, npc_enable, pc_enable, ir_enable, mdr_enable;
  logic        mar_enable, rf_write, ram_enable, psr_enable, mdr_mux_select, mem_fault;
  logic [31:0] ir_out;
  logic [3:0]  icc;
  logic [1:0]  extender_select, alub_mux_select, fault_code;
  logic [4:0]  in_pc, in_pa, in_pb;
  logic [5:0]  alu_op, ram_opcode;

  always #5 clk = ~clk;

  sparc_control_fsm #(.ALU_OP_W(6), .REG_ADDR_W(5), .MFC_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .ir_out(ir_out), .mfc(mfc), .icc(icc),
    .npc_enable(npc_enable), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .mdr_enable(mdr_enable), .mar_enable(mar_enable), .rf_write(rf_write),
    .ram_enable(ram_enable), .psr_enable(psr_enable),
    .extender_select(extender_select), .alub_mux_select(alub_mux_select),
    .mdr_mux_select(mdr_mux_select), .in_pc(in_pc), .in_pa(in_pa), .in_pb(in_pb),
    .alu_op(alu_op), .ram_opcode(ram_opcode), .mem_fault(mem_fault),
    .fault_code(fault_code)
  );

  typedef struct {
    logic        rst_n;
    logic        mfc;
    logic [3:0]  icc;
    logic [31:0] ir;
    string       tag;
    logic [7:0]  en;
    logic        flt;
    logic [1:0]  code;
    bit          c_zero;
    bit          c_pc;   logic [4:0] pc;
    bit          c_alub; logic [1:0] alub;
    bit          c_ext;  logic [1:0] ext;
    bit          c_op;   logic [5:0] op;
    bit          c_ram;  logic [5:0] ramop;
    bit          c_st;   logic [4:0] pb;
  } rec_t;

  rec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic rec_t mk(string tag, logic [31:0] ir, logic [3:0] cc);
    rec_t r;
    r.rst_n = 1'b1; r.mfc = 1'($urandom_range(0, 1)); r.icc = cc; r.ir = ir;
    r.tag = tag; r.en = '0; r.flt = 1'b0; r.code = 2'd0; r.c_zero = 1'b0;
    r.c_pc = 1'b0; r.pc = '0; r.c_alub = 1'b0; r.alub = '0; r.c_ext = 1'b0; r.ext = '0;
    r.c_op = 1'b0; r.op = '0; r.c_ram = 1'b0; r.ramop = '0; r.c_st = 1'b0; r.pb = '0;
    return r;
  endfunction

  // Bicc semantics written out per mnemonic (BN, BE, BLE, ... BVC).
  function automatic bit branch_taken(logic [3:0] cond, logic [3:0] cc);
    bit n, z, v, c;
    {n, z, v, c} = cc;
    case (cond)
      4'h0: return 1'b0;          4'h1: return z;
      4'h2: return z | (n ^ v);   4'h3: return n ^ v;
      4'h4: return c | z;         4'h5: return c;
      4'h6: return n;             4'h7: return v;
      4'h8: return 1'b1;          4'h9: return !z;
      4'hA: return !(z | (n ^ v)); 4'hB: return n == v;
      4'hC: return !(c | z);      4'hD: return !c;
      4'hE: return !n;            default: return !v;
    endcase
  endfunction

  task automatic push_rst(logic [31:0] ir, logic rst_n);
    rec_t r = mk("rst", ir, 4'h0);
    r.rst_n = rst_n; r.c_zero = 1'b1;
    q.push_back(r);
  endtask

  task automatic push_fault(logic [31:0] ir, logic [3:0] cc, logic [1:0] code);
    for (int k = 0; k < 3; k++) begin
      rec_t r = mk("fault", ir, cc);
      r.flt = 1'b1; r.code = code;
      if (k == 2) r.rst_n = 1'b0;
      q.push_back(r);
    end
    push_rst(ir, 1'b1);
  endtask

  task automatic push_data_wait(logic [31:0] ir, logic [3:0] cc, bit load, int dd,
                                int rst_at, output bit stop);
    rec_t r;
    stop = 1'b0;
    for (int k = 0; k < dd && k < T; k++) begin
      r = mk(load ? "ld_wait" : "st_wait", ir, cc);
      r.mfc = 1'b0; r.en[E_RAM] = 1'b1; r.c_ram = 1'b1; r.ramop = ir[24:19];
      if (k == rst_at) begin
        r.rst_n = 1'b0;
        q.push_back(r);
        push_rst(ir, 1'b1);
        stop = 1'b1;
        return;
      end
      q.push_back(r);
    end
    if (dd >= T) begin
      push_fault(ir, cc, 2'd2);
      stop = 1'b1;
      return;
    end
    r = mk(load ? "ld_mfc" : "st_mfc", ir, cc);
    r.mfc = 1'b1; r.en[E_RAM] = 1'b1; r.c_ram = 1'b1; r.ramop = ir[24:19];
    if (load) r.en[E_MDR] = 1'b1;
    q.push_back(r);
  endtask

  // Expected trace of one instruction given fetch/data mfc delays (in cycles).
  task automatic gen(logic [31:0] ir, logic [3:0] cc, int df, int dd, int rst_at);
    rec_t r;
    bit   stop, alu, sethi, mem, br, store;
    logic [1:0] op  = ir[31:30];
    logic [4:0] rd  = ir[29:25];
    logic [2:0] op2 = ir[24:22];
    logic [5:0] op3 = ir[24:19];
    alu   = (op == 2'd2) && (op3 inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                                         6'h10, 6'h11, 6'h12, 6'h13, 6'h14});
    sethi = (op == 2'd0) && (op2 == 3'b100);
    br    = (op == 2'd0) && (op2 == 3'b010);
    mem   = (op == 2'd3) && (op3 inside {6'h00, 6'h01, 6'h04, 6'h05});
    store = op3 inside {6'h04, 6'h05};

    r = mk("fetch", ir, cc); r.en[E_MAR] = 1'b1; q.push_back(r);
    for (int k = 0; k < df && k < T; k++) begin
      r = mk("fwait", ir, cc);
      r.mfc = 1'b0; r.en[E_RAM] = 1'b1; r.c_ram = 1'b1; r.ramop = 6'h00;
      q.push_back(r);
    end
    if (df >= T) begin
      push_fault(ir, cc, 2'd1);
      return;
    end
    r = mk("fwait_mfc", ir, cc);
    r.mfc = 1'b1; r.en[E_RAM] = 1'b1; r.en[E_IR] = 1'b1; r.c_ram = 1'b1; r.ramop = 6'h00;
    q.push_back(r);
    r = mk("decode", ir, cc); q.push_back(r);

    if (!(alu || sethi || mem || br)) begin
      push_fault(ir, cc, 2'd3);
      return;
    end

    if (alu || sethi) begin
      r = mk("exec_alu", ir, cc);
      r.en[E_RF] = (rd != 0);
      r.c_pc = (rd != 0); r.pc = rd;
      r.c_alub = 1'b1;
      if (sethi) begin
        r.alub = 2'd1; r.c_ext = 1'b1; r.ext = 2'd2;
      end else begin
        r.en[E_PSR] = (op3 >= 6'h10);
        r.c_op = 1'b1; r.op = op3;
        r.alub = ir[13] ? 2'd1 : 2'd0;
      end
      q.push_back(r);
    end else if (mem) begin
      r = mk("exec_addr", ir, cc);
      r.en[E_MAR] = 1'b1; r.c_alub = 1'b1; r.alub = ir[13] ? 2'd1 : 2'd0;
      q.push_back(r);
      if (store) begin
        r = mk("st_data", ir, cc);
        r.en[E_MDR] = 1'b1; r.c_st = 1'b1; r.pb = rd;
        q.push_back(r);
        push_data_wait(ir, cc, 1'b0, dd, rst_at, stop);
        if (stop) return;
      end else begin
        push_data_wait(ir, cc, 1'b1, dd, rst_at, stop);
        if (stop) return;
        r = mk("ld_wb", ir, cc);
        r.en[E_RF] = (rd != 0); r.c_pc = (rd != 0); r.pc = rd;
        q.push_back(r);
      end
    end else begin
      r = mk("branch", ir, cc);
      r.en[E_NPC] = 1'b1; r.c_alub = 1'b1;
      if (branch_taken(ir[28:25], cc)) begin
        r.alub = 2'd1; r.c_ext = 1'b1; r.ext = 2'd1;
      end else begin
        r.alub = 2'd2;
      end
      q.push_back(r);
      r = mk("pc_upd_br", ir, cc); r.en[E_PC] = 1'b1; q.push_back(r);
      return;
    end
    r = mk("pc_upd", ir, cc);
    r.en[E_PC] = 1'b1; r.en[E_NPC] = 1'b1; r.c_alub = 1'b1; r.alub = 2'd2;
    q.push_back(r);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] w;
    logic [5:0]  alu_ops [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                                  6'h10, 6'h11, 6'h12, 6'h13, 6'h14};
    logic [5:0]  mem_ops [4]  = '{6'h00, 6'h01, 6'h04, 6'h05};
    int k = $urandom_range(0, 9);
    w = $urandom;
    if (k <= 2) begin
      w[31:30] = 2'd2; w[24:19] = alu_ops[$urandom_range(0, 9)];
    end else if (k == 3) begin
      w[31:30] = 2'd0; w[24:22] = 3'b100;
    end else if (k <= 6) begin
      w[31:30] = 2'd3; w[24:19] = mem_ops[$urandom_range(0, 3)];
    end else if (k <= 8) begin
      w[31:30] = 2'd0; w[24:22] = 3'b010;
    end else begin
      w[31:30] = 2'd1;
    end
    return w;
  endfunction

  function automatic int rand_delay();
    return ($urandom_range(0, 15) == 0) ? T + 2 : $urandom_range(0, 3);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      reset_n = r.rst_n; mfc = r.mfc; icc = r.icc; ir_out = r.ir;
      #1;
      vectors++;
      chk({r.tag, ".en"}, 32'({npc_enable, pc_enable, ir_enable, mdr_enable,
                               mar_enable, rf_write, ram_enable, psr_enable}), 32'(r.en));
      chk({r.tag, ".mem_fault"}, 32'(mem_fault), 32'(r.flt));
      chk({r.tag, ".fault_code"}, 32'(fault_code), 32'(r.code));
      if (r.c_zero)
        chk({r.tag, ".selects"}, 32'({extender_select, alub_mux_select, mdr_mux_select,
                                     in_pc, in_pa, in_pb}) | 32'({alu_op, ram_opcode}), 32'd0);
      if (r.c_pc)   chk({r.tag, ".in_pc"}, 32'(in_pc), 32'(r.pc));
      if (r.c_alub) chk({r.tag, ".alub_mux_select"}, 32'(alub_mux_select), 32'(r.alub));
      if (r.c_ext)  chk({r.tag, ".extender_select"}, 32'(extender_select), 32'(r.ext));
      if (r.c_op)   chk({r.tag, ".alu_op"}, 32'(alu_op), 32'(r.op));
      if (r.c_ram)  chk({r.tag, ".ram_opcode"}, 32'(ram_opcode), 32'(r.ramop));
      if (r.c_st) begin
        chk({r.tag, ".mdr_mux_select"}, 32'(mdr_mux_select), 32'd1);
        chk({r.tag, ".in_pb"}, 32'(in_pb), 32'(r.pb));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; mfc = 1'b0; icc = 4'h0; ir_out = 32'h0;
    repeat (2) @(negedge clk);
    push_rst(32'h0, 1'b0);
    push_rst(32'h0, 1'b1);

    gen(32'h86004002, 4'h0, 0, 0, -1);          // add r3,r1,r2
    gen(32'hC8006008, 4'h0, 0, 3, -1);          // ld [r1+8],r4, late mfc
    gen(32'h02800004, 4'b0100, 0, 0, -1);       // be +16, taken
    gen(32'h02800004, 4'b0000, 1, 0, -1);       // be +16, not taken
    gen(32'h86004002, 4'h0, T - 1, 0, -1);      // mfc on the last allowed cycle
    gen(32'h86004002, 4'h0, T, 0, -1);          // fetch timeout
    gen(32'h81F80000, 4'h0, 0, 0, -1);          // op=2, op3=0x3F illegal
    gen(32'hC8206008, 4'h0, 0, 10, 2);          // st, reset during ST_WAIT
    gen(32'hC8006008, 4'h0, 0, T, -1);          // data timeout
    gen(32'h09000123, 4'h0, 0, 0, -1);          // sethi
    gen(32'h80004002, 4'h0, 0, 0, -1);          // add with rd=0: no write
    run_queue();

    for (int n = 0; n < 60; n++) begin
      gen(rand_ir(), 4'($urandom_range(0, 15)), rand_delay(), rand_delay(), -1);
      run_queue();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
